// File: rtl/register_write_arbiter.sv
// rtl/register_write_arbiter.sv - shared register written by NUM_REQ requesters through round-robin arbitration and a hold window
// Optional build macro ARB_FIXED_PRIO_EN: fixed priority (lowest index wins) instead of round-robin.
module register_write_arbiter #(
  parameter int WIDTH       = 32,
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*WIDTH-1:0]     wdata,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [WIDTH-1:0]             q,
  output logic [$clog2(NUM_REQ)-1:0]   q_owner,
  output logic                         busy
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [WIDTH-1:0]   shared_q;
  logic [WIDTH-1:0]   cap_data_q;
  logic [IW-1:0]      owner_q;
  logic [IW-1:0]      cap_idx_q;
  logic [3:0]         hold_cnt_q;
  logic               busy_q;

  logic [IW-1:0]      search_base;
  logic [IW-1:0]      scan_idx;
  logic [IW-1:0]      win_idx;
  logic               win_found;
  logic [WIDTH-1:0]   lane [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane[i] = wdata[i*WIDTH +: WIDTH];
  end

`ifdef ARB_FIXED_PRIO_EN
  assign search_base = '0;
`else
  logic [IW-1:0] rr_ptr_q;
  assign search_base = rr_ptr_q;
`endif

  // Scan downward so the set bit closest to search_base is the last one kept.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = IW'((int'(search_base) + k) % NUM_REQ);
      if (req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      shared_q   <= '0;
      cap_data_q <= '0;
      owner_q    <= '0;
      cap_idx_q  <= '0;
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      gnt_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            cap_data_q <= lane[win_idx];
            cap_idx_q  <= win_idx;
            gnt_q      <= NUM_REQ'(1) << win_idx;
            busy_q     <= 1'b1;
            state_q    <= WRITE;
          end
        end
        WRITE: begin
          shared_q <= cap_data_q;
          owner_q  <= cap_idx_q;
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr_q <= (cap_idx_q == IW'(NUM_REQ - 1)) ? '0 : cap_idx_q + IW'(1);
`endif
          if (HOLD_CYCLES > 0) begin
            hold_cnt_q <= 4'(HOLD_CYCLES - 1);
            state_q    <= HOLD;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        HOLD: begin
          if (hold_cnt_q == 4'd0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q - 4'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign q       = shared_q;
  assign q_owner = owner_q;
  assign busy    = busy_q;

endmodule
